// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state type and byte-select helper.
// Pure declarations: no latency, no flow control.
package aes_pkg;

  localparam int AES128_NR = 10;

  typedef logic [127:0] state_t;

  // Index 0 is unused so that rcon for round r is RCON[r]; padded to 16 entries.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Byte idx in FIPS-197 order: byte 0 is s[127:120].
  function automatic logic [7:0] get_byte(input state_t s, input int unsigned idx);
    return s[127 - 8*idx -: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, 8 bits in, 8 bits out.
// Zero latency, no flow control.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/add_round_key.sv
// AES-128 round-key XOR with on-the-fly key schedule; 1-cycle enable->ark_out/done, accepts every cycle.
// No backpressure: enable without a loaded key is dropped. AES_ARK_KEY_OUT_EN adds round_key_out.
module add_round_key
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_load,
  input  logic [127:0] key,
  input  logic         enable,
  input  logic [127:0] data,
  output logic [127:0] ark_out,
  output logic         done,
  output logic [3:0]   round,
  output logic         last,
  output logic         key_valid
`ifdef AES_ARK_KEY_OUT_EN
  ,
  output logic [127:0] round_key_out
`endif
);

  localparam logic [3:0] NR_L = 4'(NR);

  state_t     key_reg_q, key_reg_d;
  state_t     round_key_q, round_key_d;
  state_t     ark_q, ark_d;
  logic [3:0] round_q, round_d;
  logic       key_valid_q, key_valid_d;
  logic       done_q, done_d;
  logic       last_q, last_d;

  logic [31:0] sub_rot;
  logic [31:0] t_word, w0n, w1n, w2n, w3n;
  logic [7:0]  rcon_sel;
  logic        accept;

  // SubWord(RotWord(w3)): w3 is bytes 12..15, rotated to 13,14,15,12.
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (get_byte(round_key_q, 12 + ((i + 1) % 4))),
      .dout (sub_rot[31 - 8*i -: 8])
    );
  end

  always_comb begin
    rcon_sel = (round_q < NR_L) ? RCON[round_q + 4'd1] : 8'h00;
    t_word   = sub_rot ^ {rcon_sel, 24'h0};
    w0n      = round_key_q[127:96] ^ t_word;
    w1n      = round_key_q[95:64]  ^ w0n;
    w2n      = round_key_q[63:32]  ^ w1n;
    w3n      = round_key_q[31:0]   ^ w2n;
  end

  assign accept = enable & key_valid_q & ~key_load;

  always_comb begin
    key_reg_d   = key_reg_q;
    round_key_d = round_key_q;
    ark_d       = ark_q;
    round_d     = round_q;
    key_valid_d = key_valid_q;
    done_d      = 1'b0;
    last_d      = last_q;
    if (key_load) begin
      key_reg_d   = key;
      round_key_d = key;
      round_d     = 4'd0;
      key_valid_d = 1'b1;
    end else if (accept) begin
      ark_d  = data ^ round_key_q;
      done_d = 1'b1;
      last_d = (round_q == NR_L);
      if (round_q < NR_L) begin
        round_key_d = {w0n, w1n, w2n, w3n};
        round_d     = round_q + 4'd1;
      end else begin
        // Wrap so the next block reuses the same cipher key without reloading.
        round_key_d = key_reg_q;
        round_d     = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_reg_q   <= '0;
      round_key_q <= '0;
      ark_q       <= '0;
      round_q     <= '0;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      key_reg_q   <= key_reg_d;
      round_key_q <= round_key_d;
      ark_q       <= ark_d;
      round_q     <= round_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
      last_q      <= last_d;
    end
  end

  assign ark_out   = ark_q;
  assign done      = done_q;
  assign round     = round_q;
  assign last      = last_q;
  assign key_valid = key_valid_q;
`ifdef AES_ARK_KEY_OUT_EN
  assign round_key_out = round_key_q;
`endif

endmodule
